// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and sizing helpers for the debounce bank
package debounce_pkg;

    localparam int DEBOUNCE_SYNC_STAGES = 2;

    typedef struct packed {
        logic rise;
        logic fall;
    } debounce_event_t;

    // Wide enough to hold STABLE_TICKS; never narrower than one bit.
    function automatic int counter_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced channel; DEBOUNCE_BANK_SYNC_EN adds a 2-flop input synchroniser
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = 10000,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_tick,
    input  logic            i_data,
    output logic            o_level,
    output debounce_event_t o_event
);

    localparam int            CW   = counter_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic            sample;
    logic            level_q;
    logic [CW-1:0]   count_q;
    debounce_event_t event_q;

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [DEBOUNCE_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= {DEBOUNCE_SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[DEBOUNCE_SYNC_STAGES-2:0], i_data};
        end
    end

    assign sample = sync_q[DEBOUNCE_SYNC_STAGES-1];
`else
    assign sample = i_data;
`endif

    // An agreeing sample clears the window even when no tick is present.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            level_q <= RESET_LEVEL;
            count_q <= '0;
            event_q <= '0;
        end else begin
            event_q <= '0;
            if (sample == level_q) begin
                count_q <= '0;
            end else if (i_tick) begin
                if (count_q == LAST) begin
                    level_q      <= sample;
                    count_q      <= '0;
                    event_q.rise <= sample;
                    event_q.fall <= ~sample;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign o_level = level_q;
    assign o_event = event_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel bidirectional debouncer top; DEBOUNCE_BANK_SYNC_EN enables input synchronisers
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   CHANNELS     = 4,
    parameter int   STABLE_TICKS = 10000,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_tick,
    input  logic [CHANNELS-1:0] i_data,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_any_event
);

    debounce_event_t chan_event [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_chan (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_tick    (i_tick),
            .i_data    (i_data[g]),
            .o_level   (o_level[g]),
            .o_event   (chan_event[g])
        );

        assign o_rise[g] = chan_event[g].rise;
        assign o_fall[g] = chan_event[g].fall;
    end

    // Built from event registers only, so no input reaches this output combinationally.
    assign o_any_event = |{o_rise, o_fall};

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank
module tb_debounce_bank;

    localparam int ST = 8;
`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT  = SYNC + ST;
    localparam int LAT1 = SYNC + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] data;
    logic [3:0] level, rise, fall;
    logic       any_ev;
    logic [3:0] data1;
    logic [3:0] level1, rise1, fall1;
    logic       any_ev1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit presc = 1'b0;

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(4), .STABLE_TICKS(ST), .RESET_LEVEL(1'b0)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_tick      (tick),
        .i_data      (data),
        .o_level     (level),
        .o_rise      (rise),
        .o_fall      (fall),
        .o_any_event (any_ev)
    );

    debounce_bank #(.CHANNELS(4), .STABLE_TICKS(1), .RESET_LEVEL(1'b0)) dut1 (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_tick      (1'b1),
        .i_data      (data1),
        .o_level     (level1),
        .o_rise      (rise1),
        .o_fall      (fall1),
        .o_any_event (any_ev1)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are sampled 1ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            tick = presc ? (cyc % 4 == 0) : 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        tick  = 1'b1;
        data  = 4'hF;
        data1 = 4'h0;

        // Reset holds everything low regardless of pins.
        step(3);
        check_vec("rst_level", level, 4'h0);
        check_vec("rst_rise", rise, 4'h0);
        check_vec("rst_fall", fall, 4'h0);
        check_vec("rst_any", any_ev, 1'b0);
        check_vec("rst_level_st1", level1, 4'h0);

        rst_n = 1'b1;
        step(LAT - 1);
        check_vec("all_rise_early", level, 4'h0);
        step(1);
        check_vec("all_rise_level", level, 4'hF);
        check_vec("all_rise_pulse", rise, 4'hF);
        check_vec("all_rise_fall", fall, 4'h0);
        check_vec("all_rise_any", any_ev, 1'b1);
        step(1);
        check_vec("all_rise_pulse_end", rise, 4'h0);
        check_vec("all_rise_any_end", any_ev, 1'b0);

        // Bring ch0 low, then glitch-rejection on its rise.
        data = 4'hE;
        step(LAT);
        check_vec("ch0_fall_pulse", fall, 4'h1);
        check_vec("ch0_fall_level", level, 4'hE);
        step(1);
        data = 4'hF;
        step(7);
        data = 4'hE;
        step(1);
        data = 4'hF;
        step(LAT - 1);
        check_vec("glitch_no_change", level, 4'hE);
        step(1);
        check_vec("glitch_rise_pulse", rise, 4'h1);
        check_vec("glitch_rise_level", level, 4'hF);

        // Fall path on ch1, others untouched.
        data = 4'hD;
        step(LAT - 1);
        check_vec("ch1_fall_early", fall, 4'h0);
        step(1);
        check_vec("ch1_fall_pulse", fall, 4'h2);
        check_vec("ch1_fall_level", level, 4'hD);
        check_vec("ch1_fall_no_rise", rise, 4'h0);
        step(1);
        check_vec("ch1_fall_pulse_end", fall, 4'h0);

        // Prescaled tick: ch2 low at full rate, then rise with a 1-in-4 tick.
        data = 4'h9;
        step(LAT);
        check_vec("ch2_low_level", level, 4'h9);
        presc = 1'b1;
        step(1);
        data = 4'hD;
        n = 0;
        while (level[2] !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        check_vec("presc_window", (n >= SYNC + 4 * (ST - 1) && n <= SYNC + 4 * ST), 1'b1);
        check_vec("presc_rise_pulse", rise, 4'h4);

        // A one-cycle return between ticks restarts the window on ch0.
        data = 4'hC;
        step(20);
        data = 4'hD;
        step(1);
        data = 4'hC;
        step(24);
        check_vec("presc_restart_hold", level, 4'hD);
        presc = 1'b0;
        step(LAT + 2);
        check_vec("presc_restart_done", level, 4'hC);

        // Mid-window reset discards the partial count.
        data  = 4'h0;
        rst_n = 1'b0;
        #1;
        check_vec("async_rst_level", level, 4'h0);
        step(2);
        rst_n = 1'b1;
        step(3);
        data = 4'h8;
        step(5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(LAT - 1);
        check_vec("midrst_no_event", level, 4'h0);
        check_vec("midrst_no_any", any_ev, 1'b0);
        step(1);
        check_vec("midrst_rise_level", level, 4'h8);
        check_vec("midrst_rise_pulse", rise, 4'h8);

        // STABLE_TICKS=1 instance: single-cycle pin pulse both accepted and undone.
        data1 = 4'h1;
        step(1);
        check_vec("st1_first_cycle", level1, (LAT1 == 1) ? 4'h1 : 4'h0);
        data1 = 4'h0;
        step(LAT1 - 1);
        check_vec("st1_rise_level", level1, 4'h1);
        check_vec("st1_rise_pulse", rise1, 4'h1);
        step(1);
        check_vec("st1_fall_level", level1, 4'h0);
        check_vec("st1_fall_pulse", fall1, 4'h1);
        check_vec("st1_fall_no_rise", rise1, 4'h0);
        check_vec("st1_fall_any", any_ev1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
